// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo link test: FSM encoding, default baud
// constants and the byte-pattern step.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RX,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int Oversample = 3;
  localparam int Width      = 10;
  localparam int Incr       = 78;

  localparam logic [7:0] PatternStep = 8'd1;

endpackage

// File: rtl/edge_rise.sv
// One-flop rising-edge detector; rise is high in the cycle sig first reads 1.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_prev_reg <= 1'b0;
    else       sig_prev_reg <= sig;
  end

  assign rise = sig & ~sig_prev_reg;

endmodule

// File: rtl/uart_echo_checker.sv
// Echo link tester: sends an incrementing byte pattern through a uart and
// checks each echoed byte, counting mismatches, framing errors, overruns, timeouts.
module uart_echo_checker
  import uart_pkg::*;
#(
  parameter int              Timeout    = 200000,
  parameter int              CountWidth = 8,
  parameter logic [7:0]      Seed       = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CountWidth-1:0] len,
  output logic [7:0]            din,
  output logic                  send,
  input  logic                  txbusy,
  input  logic [7:0]            dout,
  input  logic                  ready,
  input  logic                  rxerr,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic [CountWidth-1:0] sent_count,
  output logic [CountWidth-1:0] err_count
);

  localparam int TmoW = $clog2(Timeout + 1);

  state_t                state_reg;
  logic [CountWidth-1:0] len_reg;
  logic [7:0]            expect_reg;
  logic [7:0]            rx_data_reg;
  logic                  rx_pending_reg;
  logic                  rx_bad_reg;
  logic [TmoW-1:0]       tmo_cnt_reg;

  logic [1:0] rx_raw;
  logic [1:0] rx_rise;
  logic       ready_rise;
  logic       rxerr_rise;

  assign rx_raw = {rxerr, ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      edge_rise u_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (rx_raw[gi]),
        .rise  (rx_rise[gi])
      );
    end
  endgenerate

  assign ready_rise = rx_rise[0];
  assign rxerr_rise = rx_rise[1];

  logic                  rx_edge;
  logic                  overrun;
  logic                  check_err;
  logic                  counting;
  logic                  tmo_hit;
  logic [1:0]            err_inc;
  logic [CountWidth:0]   err_sum;
  logic [CountWidth-1:0] err_sat;

  always_comb begin
    rx_edge   = (state_reg != ST_IDLE) && (ready_rise || rxerr_rise);
    overrun   = rx_edge && rx_pending_reg;
    check_err = (state_reg == ST_CHECK) && (rx_bad_reg || (rx_data_reg != expect_reg));
    counting  = (state_reg == ST_SEND) || (state_reg == ST_WAIT_TX) ||
                (state_reg == ST_WAIT_RX);
    // Counter is loaded with 1 as send rises, so this fires Timeout-1 cycles
    // later and done lands no more than Timeout cycles after send.
    tmo_hit   = counting && (tmo_cnt_reg == TmoW'(Timeout - 1));
    err_inc   = 2'(overrun) + 2'(check_err) + 2'(tmo_hit);
    err_sum   = {1'b0, err_count} + {{(CountWidth - 1){1'b0}}, err_inc};
    err_sat   = err_sum[CountWidth] ? '1 : err_sum[CountWidth-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      len_reg        <= '0;
      expect_reg     <= '0;
      rx_data_reg    <= '0;
      rx_pending_reg <= 1'b0;
      rx_bad_reg     <= 1'b0;
      tmo_cnt_reg    <= '0;
      din            <= '0;
      send           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timed_out      <= 1'b0;
      sent_count     <= '0;
      err_count      <= '0;
    end else begin
      done <= 1'b0;

      // A second edge while a byte is still pending is dropped (overrun).
      if (rx_edge && !rx_pending_reg) begin
        rx_pending_reg <= 1'b1;
        rx_bad_reg     <= rxerr_rise;
        if (ready_rise) rx_data_reg <= dout;
      end

      if (state_reg != ST_IDLE) err_count <= err_sat;
      if (counting) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;

      if (tmo_hit) begin
        send      <= 1'b0;
        timed_out <= 1'b1;
        state_reg <= ST_DONE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              len_reg        <= len;
              sent_count     <= '0;
              err_count      <= '0;
              pass           <= 1'b0;
              timed_out      <= 1'b0;
              expect_reg     <= Seed;
              rx_pending_reg <= 1'b0;
              rx_bad_reg     <= 1'b0;
              tmo_cnt_reg    <= TmoW'(1);
              busy           <= 1'b1;
              if (len == '0) begin
                state_reg <= ST_DONE;
              end else begin
                din       <= Seed;
                send      <= 1'b1;
                state_reg <= ST_SEND;
              end
            end
          end
          ST_SEND: begin
            if (txbusy) begin
              send      <= 1'b0;
              state_reg <= ST_WAIT_TX;
            end
          end
          ST_WAIT_TX: begin
            if (!txbusy) begin
              sent_count <= sent_count + 1'b1;
              state_reg  <= ST_WAIT_RX;
            end
          end
          ST_WAIT_RX: begin
            if (rx_pending_reg) state_reg <= ST_CHECK;
          end
          ST_CHECK: begin
            rx_pending_reg <= 1'b0;
            expect_reg     <= expect_reg + PatternStep;
            if (sent_count == len_reg) begin
              state_reg <= ST_DONE;
            end else begin
              din         <= expect_reg + PatternStep;
              send        <= 1'b1;
              tmo_cnt_reg <= TmoW'(1);
              state_reg   <= ST_SEND;
            end
          end
          ST_DONE: begin
            done      <= 1'b1;
            pass      <= (err_sat == '0) && !timed_out;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: a uart/echo model answers each send, a queue
// holds the expected byte pattern, and each scenario task checks its outcome.
module tb_uart_echo_checker;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          sel = 1'b0;
  logic [CW-1:0] len = '0;
  logic          txbusy = 1'b0;
  logic [7:0]    dout = 8'h00;
  logic          ready = 1'b0;
  logic          rxerr = 1'b0;

  logic          start_a, start_b;
  logic [7:0]    a_din, b_din;
  logic          a_send, b_send, a_busy, b_busy, a_done, b_done;
  logic          a_pass, b_pass, a_to, b_to;
  logic [CW-1:0] a_sent, b_sent, a_err, b_err;

  logic [7:0]    din_m;
  logic          send_m, busy_m, done_m, pass_m, to_m;
  logic [CW-1:0] sent_m, err_m;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  uart_echo_checker #(.Timeout(500), .CountWidth(CW), .Seed(8'h41)) dut (
    .clk(clk), .reset(reset), .start(start_a), .len(len),
    .din(a_din), .send(a_send), .txbusy(txbusy), .dout(dout),
    .ready(ready), .rxerr(rxerr), .busy(a_busy), .done(a_done),
    .pass(a_pass), .timed_out(a_to), .sent_count(a_sent), .err_count(a_err)
  );

  uart_echo_checker #(.Timeout(500), .CountWidth(CW), .Seed(8'hFE)) dut_fe (
    .clk(clk), .reset(reset), .start(start_b), .len(len),
    .din(b_din), .send(b_send), .txbusy(txbusy), .dout(dout),
    .ready(ready), .rxerr(rxerr), .busy(b_busy), .done(b_done),
    .pass(b_pass), .timed_out(b_to), .sent_count(b_sent), .err_count(b_err)
  );

  assign din_m  = sel ? b_din  : a_din;
  assign send_m = sel ? b_send : a_send;
  assign busy_m = sel ? b_busy : a_busy;
  assign done_m = sel ? b_done : a_done;
  assign pass_m = sel ? b_pass : a_pass;
  assign to_m   = sel ? b_to   : a_to;
  assign sent_m = sel ? b_sent : a_sent;
  assign err_m  = sel ? b_err  : a_err;

  int total = 0;
  int bad = 0;

  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   send_rises = 0;
  int   last_rise_cyc = 0;
  logic send_prev = 1'b0;

  // 0 normal echo, 1 corrupt byte 3, 2 silent, 3 rxerr on byte 2 + overrun on byte 4
  int         mode = 0;
  int         mdl_idx = 0;
  bit         mdl_rxwait = 1'b0;
  logic [7:0] mdl_byte = 8'h00;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (done_m) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (send_m && !send_prev) begin
      send_rises++;
      last_rise_cyc = cyc;
    end
    send_prev = send_m;
  end

  // uart + far-end echo model: ~40 cycle transmit, echo 100 cycles after txbusy falls
  initial forever begin
    @(negedge clk);
    if (start) begin
      mdl_idx = 0;
    end else if (send_m && !txbusy && !reset) begin
      mdl_idx++;
      mdl_byte = din_m;
      obs_q.push_back(din_m);
      $display("tx byte %0d = %02h at cycle %0d", mdl_idx, din_m, cyc);
      @(negedge clk);
      txbusy = 1'b1;
      repeat (40) @(negedge clk);
      txbusy = 1'b0;
      mdl_rxwait = 1'b1;
      if (mode != 2) begin
        repeat (100) @(negedge clk);
        if (mode == 3 && mdl_idx == 2) begin
          rxerr = 1'b1;
          repeat (2) @(negedge clk);
          rxerr = 1'b0;
        end else begin
          dout  = (mode == 1 && mdl_idx == 3) ? (mdl_byte ^ 8'h01) : mdl_byte;
          ready = 1'b1;
          @(negedge clk);
          ready = 1'b0;
          if (mode == 3 && mdl_idx == 4) begin
            @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
          end
        end
      end
      mdl_rxwait = 1'b0;
    end
  end

  // Starts a run, fills the expected queue and waits (bounded) for done.
  task automatic run_len(input logic [7:0] seed, input int n, output int dn);
    int base;
    logic [7:0] e;
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      e = seed + 8'(i);
      exp_q.push_back(e);
    end
    base = done_cnt;
    @(posedge clk);
    #1 len = CW'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 5000 && done_cnt == base; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    dn = done_cnt - base;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (send_m !== 1'b0) begin bad++; $display("FAIL reset_send got=%0b want=0", send_m); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_m); end
    total++; if (done_m !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done_m); end
    total++; if (pass_m !== 1'b0) begin bad++; $display("FAIL reset_pass got=%0b want=0", pass_m); end
    total++; if (to_m !== 1'b0) begin bad++; $display("FAIL reset_timed_out got=%0b want=0", to_m); end
    total++; if (din_m !== 8'h00) begin bad++; $display("FAIL reset_din got=%02h want=00", din_m); end
    total++; if (sent_m !== '0) begin bad++; $display("FAIL reset_sent got=%0d want=0", sent_m); end
    total++; if (err_m !== '0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_m); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal();
    int dn;
    logic [7:0] e, o;
    sel = 1'b0; mode = 0;
    run_len(8'h41, 4, dn);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL normal_nbytes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL normal_din got=%02h want=%02h", o, e); end
    end
    total++; if (dn != 1) begin bad++; $display("FAIL normal_done_pulses got=%0d want=1", dn); end
    total++; if (pass_m !== 1'b1) begin bad++; $display("FAIL normal_pass got=%0b want=1", pass_m); end
    total++; if (err_m !== 8'd0) begin bad++; $display("FAIL normal_err got=%0d want=0", err_m); end
    total++; if (sent_m !== 8'd4) begin bad++; $display("FAIL normal_sent got=%0d want=4", sent_m); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL normal_busy got=%0b want=0", busy_m); end
  endtask

  task automatic test_corrupt();
    int dn;
    logic [7:0] e, o;
    sel = 1'b0; mode = 1;
    run_len(8'h41, 4, dn);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL corrupt_din got=%02h want=%02h", o, e); end
    end
    total++; if (dn != 1) begin bad++; $display("FAIL corrupt_done_pulses got=%0d want=1", dn); end
    total++; if (err_m !== 8'd1) begin bad++; $display("FAIL corrupt_err got=%0d want=1", err_m); end
    total++; if (pass_m !== 1'b0) begin bad++; $display("FAIL corrupt_pass got=%0b want=0", pass_m); end
    total++; if (sent_m !== 8'd4) begin bad++; $display("FAIL corrupt_sent got=%0d want=4", sent_m); end
    total++; if (to_m !== 1'b0) begin bad++; $display("FAIL corrupt_timed_out got=%0b want=0", to_m); end
  endtask

  task automatic test_timeout();
    int dn;
    int lat;
    sel = 1'b0; mode = 2;
    run_len(8'h41, 4, dn);
    lat = done_cyc - last_rise_cyc;
    total++; if (dn != 1) begin bad++; $display("FAIL timeout_done_pulses got=%0d want=1", dn); end
    total++; if (lat > 500 || lat < 1) begin bad++; $display("FAIL timeout_latency got=%0d want=1..500", lat); end
    total++; if (to_m !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%0b want=1", to_m); end
    total++; if (err_m !== 8'd1) begin bad++; $display("FAIL timeout_err got=%0d want=1", err_m); end
    total++; if (sent_m !== 8'd1) begin bad++; $display("FAIL timeout_sent got=%0d want=1", sent_m); end
    total++; if (send_m !== 1'b0) begin bad++; $display("FAIL timeout_send got=%0b want=0", send_m); end
    total++; if (pass_m !== 1'b0) begin bad++; $display("FAIL timeout_pass got=%0b want=0", pass_m); end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_wrap();
    int dn;
    logic [7:0] e, o;
    sel = 1'b1; mode = 0;
    run_len(8'hFE, 4, dn);
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL wrap_nbytes got=%0d want=4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wrap_din got=%02h want=%02h", o, e); end
    end
    total++; if (pass_m !== 1'b1) begin bad++; $display("FAIL wrap_pass got=%0b want=1", pass_m); end
    total++; if (err_m !== 8'd0) begin bad++; $display("FAIL wrap_err got=%0d want=0", err_m); end
    sel = 1'b0;
  endtask

  task automatic test_rxerr_overrun();
    int dn;
    sel = 1'b0; mode = 3;
    run_len(8'h41, 4, dn);
    total++; if (dn != 1) begin bad++; $display("FAIL rxerr_done_pulses got=%0d want=1", dn); end
    total++; if (err_m !== 8'd2) begin bad++; $display("FAIL rxerr_err got=%0d want=2", err_m); end
    total++; if (pass_m !== 1'b0) begin bad++; $display("FAIL rxerr_pass got=%0b want=0", pass_m); end
    total++; if (sent_m !== 8'd4) begin bad++; $display("FAIL rxerr_sent got=%0d want=4", sent_m); end
    mode = 0;
  endtask

  task automatic test_reset_midrun();
    int dn;
    int k;
    logic [7:0] o;
    sel = 1'b0; mode = 0;
    @(posedge clk);
    #1 len = CW'(4);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (!(mdl_idx == 2 && mdl_rxwait) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    total++; if (k >= 3000) begin bad++; $display("FAIL midrun_reach_byte2 got=timeout want=byte2_wait_rx"); end
    repeat (10) @(negedge clk);
    total++; if (sent_m !== 8'd2) begin bad++; $display("FAIL midrun_sent_before got=%0d want=2", sent_m); end
    reset = 1'b1;
    #1;
    total++; if (send_m !== 1'b0) begin bad++; $display("FAIL midrun_send got=%0b want=0", send_m); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL midrun_busy got=%0b want=0", busy_m); end
    total++; if (sent_m !== 8'd0) begin bad++; $display("FAIL midrun_sent got=%0d want=0", sent_m); end
    total++; if (err_m !== 8'd0) begin bad++; $display("FAIL midrun_err got=%0d want=0", err_m); end
    @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    run_len(8'h41, 1, dn);
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL midrun_rerun_nbytes got=%0d want=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      total++; if (o !== exp_q[0]) begin bad++; $display("FAIL midrun_rerun_din got=%02h want=%02h", o, exp_q[0]); end
    end
    total++; if (pass_m !== 1'b1) begin bad++; $display("FAIL midrun_rerun_pass got=%0b want=1", pass_m); end
  endtask

  task automatic test_len_zero();
    int rises0;
    sel = 1'b0; mode = 0;
    rises0 = send_rises;
    @(posedge clk);
    #1 len = '0;
    start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    total++; if (done_m !== 1'b0) begin bad++; $display("FAIL len0_done_early got=%0b want=0", done_m); end
    total++; if (pass_m !== 1'b0) begin bad++; $display("FAIL len0_pass_cleared got=%0b want=0", pass_m); end
    total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL len0_busy got=%0b want=1", busy_m); end
    @(negedge clk);
    total++; if (done_m !== 1'b1) begin bad++; $display("FAIL len0_done got=%0b want=1", done_m); end
    total++; if (pass_m !== 1'b1) begin bad++; $display("FAIL len0_pass got=%0b want=1", pass_m); end
    @(negedge clk);
    total++; if (done_m !== 1'b0) begin bad++; $display("FAIL len0_done_width got=%0b want=0", done_m); end
    total++; if (send_rises != rises0) begin bad++; $display("FAIL len0_send got=%0d want=%0d", send_rises, rises0); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_corrupt();
    test_timeout();
    test_wrap();
    test_rxerr_overrun();
    test_reset_midrun();
    test_len_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_echo_checker.md
# uart_echo_checker

Link-test initiator for the UART echo path: drives the transmit side of a `uart` instance with a seeded incrementing byte sequence and checks each byte the far-end echo responder returns on the receive side. It sits beside a `uart` instance in a test top and reports pass/fail, an error count and timeout status, so a board-to-board or board-to-host echo link is self-checking.

## Interface
- `Timeout`, 200000: clk cycles allowed per byte, from send assertion to echo arrival (~16.7 ms at 12 MHz).
- `CountWidth`, 8: width of `len`, `sent_count` and `err_count`.
- `Seed`, 8'h00: first byte of the pattern.
- `clk`  in  1  system clock (12 MHz on target).
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `len`  in  CountWidth  bytes per run; latched on accepted `start`.
- `din`  out  8  byte to the uart transmitter.
- `send`  out  1  transmit request to the uart.
- `txbusy`  in  1  uart transmitter busy.
- `dout`  in  8  byte from the uart receiver.
- `ready`  in  1  uart receive complete; a rising edge marks a new byte.
- `rxerr`  in  1  uart framing error; a rising edge marks a bad byte.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  last run had zero errors and no timeout.
- `timed_out`  out  1  last run was aborted by timeout.
- `sent_count`  out  CountWidth  bytes transmitted in the current or last run.
- `err_count`  out  CountWidth  mismatches, rxerr events, overruns and timeouts; saturates at all-ones.

## Operation
- Reset values: all outputs 0, `din`=0, state IDLE. Reset mid-run drops `send` immediately (asynchronous) and discards the run.
- States: IDLE, SEND, WAIT_TX, WAIT_RX, CHECK, DONE.
- IDLE: `start`=1 latches `len`, clears counts, `pass` and `timed_out`, loads expected=`Seed`. Next state is DONE if `len`=0, else SEND.
- SEND: `din`=expected, `send`=1. `send` stays high until `txbusy` is sampled high, then the block enters WAIT_TX.
- WAIT_TX: `send`=0. When `txbusy` is sampled low, `sent_count`++ and the block enters WAIT_RX.
- WAIT_RX: waits for `rx_pending`, then enters CHECK.
- CHECK, one cycle:
  - Error if the captured byte ≠ expected, or if the captured byte came with an rxerr.
  - Clears `rx_pending` and increments expected (8-bit wrap).
  - If `sent_count`=`len`, next state is DONE; else SEND.
- DONE: `done`=1 for one cycle. `pass` = (`err_count`=0 and not `timed_out`). Then IDLE.
- Receive capture:
  - Active in every non-IDLE state. A `ready` rising edge latches `dout` and sets `rx_pending`. An `rxerr` rising edge sets `rx_pending` with a bad flag.
  - An edge while `rx_pending` is already set is an overrun: `err_count`++, the new data is dropped.
  - Edges in IDLE are ignored.
- Timeout counter: cleared on entering SEND, counts in SEND, WAIT_TX and WAIT_RX. Reaching `Timeout` gives `err_count`++, `timed_out`=1, `send`=0, and the block enters DONE (abort).
- `start` while `busy` is ignored. `busy`=1 in every state except IDLE.

## Timing
- `start` is sampled at edge N. Then `busy`=1 and `send`=1 with `din`=`Seed` after edge N+1.
- `send` falls the cycle after `txbusy` is first sampled high.
- A `ready` edge sampled at edge M sets `rx_pending` after M. CHECK occurs at M+1 at the earliest (M+2 if it arrives during WAIT_TX).
- One byte is in flight at a time; there is no pipelining.
- `len`=0 gives `done` two cycles after the `start` sample, with no `send` pulse.
- `ready` and `rxerr` rising on the same cycle count as one bad byte.
- `sent_count` and `err_count` stay valid after `done` until the next accepted `start`.

## Structure
- Shared package `uart_pkg`: state encoding constants, default baud constants (Oversample=3, Width=10, Incr=78), and the pattern step constant (1).
- Sub-module `edge_rise`: one-flop rising-edge detector, async reset. Instantiated once for `ready` and once for `rxerr`.
- Remaining logic (FSM, timeout counter, capture, saturating counters) lives in the top of the block, ~200 lines.

## Test plan
- `len`=4, `Seed`=8'h41, bench echo model returns each byte about 100 cycles after `txbusy` falls.
  - Required: `din` sequence 41,42,43,44; one `done`; `pass`=1; `err_count`=0; `sent_count`=4.
- Same setup, but the echo XORs byte 3 with 8'h01.
  - Required: `err_count`=1, `pass`=0, `sent_count`=4, `timed_out`=0.
- Echo model silent, `Timeout`=500.
  - Required: `done` within 500 cycles after the first `send` rises; `timed_out`=1; `err_count`=1; `sent_count`=1; `send`=0.
- `Seed`=8'hFE, `len`=4.
  - Required: bytes FE,FF,00,01 are all accepted; `pass`=1.
- Echo pulses `rxerr` instead of `ready` on byte 2, plus a second `ready` edge during byte 4 while `rx_pending` is set.
  - Required: `err_count`=2, `pass`=0.
- `reset` asserted during WAIT_RX of byte 2.
  - Required: `send`, `busy` and the counts read 0 immediately.
  - Then `start` with `len`=1 gives `din`=`Seed` and `pass`=1.
- `len`=0.
  - Required: `done` two cycles after `start`, `pass`=1, `send` never asserted.
